// File: rtl/uart_hex_rx.sv
// uart_hex_rx: 8N1 UART receiver that parses ASCII hex lines into a 16-bit word.
// Define UART_HEX_RX_PARITY_EN for 8E1 framing with even-parity checking.
module uart_hex_rx #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        frame_err,
    output logic        hex_err
);
    localparam int CPB = CLK_HZ / BAUD;
    localparam int CW  = $clog2(CPB + 1);
    localparam logic [CW-1:0] HALF = CW'(CPB / 2);
    localparam logic [CW-1:0] FULL = CW'(CPB - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA,
`ifdef UART_HEX_RX_PARITY_EN
        PARITY,
`endif
        STOP, BREAK
    } state_t;

    state_t state_q, state_d;
    logic          rx_m_q, rx_m_d, rx_s_q, rx_s_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d, byte_out_q, byte_out_d;
    logic          byte_valid_q, byte_valid_d, frame_err_q, frame_err_d;
    logic [15:0]   shadow_q, shadow_d, data_out_q, data_out_d;
    logic [2:0]    nib_cnt_q, nib_cnt_d;
    logic          data_valid_q, data_valid_d, hex_err_q, hex_err_d;
    logic          par_bad, is_num, is_uc, is_lc, is_term;
    logic [3:0]    nib;
`ifdef UART_HEX_RX_PARITY_EN
    logic          par_err_q, par_err_d;
    assign par_bad = par_err_q;
`else
    assign par_bad = 1'b0;
`endif

    always_comb begin
        rx_m_d       = rx;
        rx_s_d       = rx_m_q;
        state_d      = state_q;
        clk_cnt_d    = clk_cnt_q + 1'b1;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
`ifdef UART_HEX_RX_PARITY_EN
        par_err_d    = par_err_q;
`endif
        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                if (!rx_s_q) state_d = START;
            end
            START: if (clk_cnt_q == HALF) begin
                clk_cnt_d = '0;
                state_d   = rx_s_q ? IDLE : DATA;
            end
            DATA: if (clk_cnt_q == FULL) begin
                clk_cnt_d = '0;
                shift_d   = {rx_s_q, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef UART_HEX_RX_PARITY_EN
                if (bit_cnt_q == 3'd7) state_d = PARITY;
`else
                if (bit_cnt_q == 3'd7) state_d = STOP;
`endif
            end
`ifdef UART_HEX_RX_PARITY_EN
            PARITY: if (clk_cnt_q == FULL) begin
                clk_cnt_d = '0;
                par_err_d = ^shift_q ^ rx_s_q;
                state_d   = STOP;
            end
`endif
            STOP: if (clk_cnt_q == FULL) begin
                clk_cnt_d = '0;
                if (rx_s_q && !par_bad) begin
                    byte_out_d   = shift_q;
                    byte_valid_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = rx_s_q ? IDLE : BREAK;
                end
            end
            // a line held low must return high before another frame can start
            BREAK: begin
                clk_cnt_d = '0;
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        is_num       = byte_out_q >= 8'h30 && byte_out_q <= 8'h39;
        is_uc        = byte_out_q >= 8'h41 && byte_out_q <= 8'h46;
        is_lc        = byte_out_q >= 8'h61 && byte_out_q <= 8'h66;
        is_term      = byte_out_q == 8'h0D || byte_out_q == 8'h0A;
        nib          = is_num ? byte_out_q[3:0] : byte_out_q[3:0] + 4'd9;
        shadow_d     = shadow_q;
        nib_cnt_d    = nib_cnt_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        hex_err_d    = 1'b0;
        if (byte_valid_q) begin
            if (is_num || is_uc || is_lc) begin
                shadow_d  = {shadow_q[11:0], nib};
                nib_cnt_d = (nib_cnt_q == 3'd4) ? 3'd4 : nib_cnt_q + 1'b1;
            end else begin
                shadow_d  = '0;
                nib_cnt_d = '0;
                hex_err_d = !is_term;
                if (is_term && nib_cnt_q != 3'd0) begin
                    data_out_d   = shadow_q;
                    data_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rx_m_q       <= 1'b1;
            rx_s_q       <= 1'b1;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_out_q   <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            shadow_q     <= '0;
            nib_cnt_q    <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            hex_err_q    <= 1'b0;
`ifdef UART_HEX_RX_PARITY_EN
            par_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rx_m_q       <= rx_m_d;
            rx_s_q       <= rx_s_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            shadow_q     <= shadow_d;
            nib_cnt_q    <= nib_cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            hex_err_q    <= hex_err_d;
`ifdef UART_HEX_RX_PARITY_EN
            par_err_q    <= par_err_d;
`endif
        end
    end

    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign hex_err    = hex_err_q;
endmodule
